// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] STALL_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_busy_timer.sv
// Multi-cycle MDU occupancy timer: counts down the busy window of a mult/div
// and flags its last cycle.
module mdu_busy_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  input  logic hold,
  output logic busy,
  output logic done
);

  mdu_state_e       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;

  // State and countdown registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MDU_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next-state: a start waits out a memory freeze, but a running count never pauses.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      MDU_IDLE: begin
        if (start && !hold) begin
          state_nx_s = MDU_BUSY;
          cnt_nx_s   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        end else begin
          state_nx_s = MDU_IDLE;
        end
      end
      MDU_BUSY: begin
        if (cnt_r == CNT_W'(32'd1)) begin
          state_nx_s = MDU_IDLE;
          cnt_nx_s   = '0;
        end else begin
          cnt_nx_s = cnt_r - CNT_W'(32'd1);
        end
      end
      default: begin
        state_nx_s = MDU_IDLE;
        cnt_nx_s   = '0;
      end
    endcase
  end

  assign busy = (state_r == MDU_BUSY);
  assign done = (state_r == MDU_BUSY) && (cnt_r == CNT_W'(32'd1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register enable/flush generation for load-use, branch, memory-wait
// and MDU hazards. Build with MDU_STALL_EN to enable multi-cycle MDU stalls.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_hilo,
  input  logic        ex_memread,
  input  logic [4:0]  ex_wreg,
  input  logic        ex_br_taken,
  input  logic        mdu_start,
  input  logic        mdu_div,
  input  logic        mem_stall,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        mdu_busy,
  output logic        mdu_done,
  output logic [31:0] stall_cnt
);

  logic        mdu_busy_s, mdu_done_s;
  logic        hilo_hz_s, loaduse_hz_s;
  logic        pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s;
  logic        exmem_en_s, memwb_en_s;
  logic [31:0] stall_cnt_r;

`ifdef MDU_STALL_EN
  mdu_busy_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mdu_start),
    .is_div (mdu_div),
    .hold   (mem_stall),
    .busy   (mdu_busy_s),
    .done   (mdu_done_s)
  );
  assign hilo_hz_s = mdu_busy_s & id_hilo;
`else
  // Single-cycle MDU: these inputs have no effect on the controls.
  logic unused_mdu_s;
  assign unused_mdu_s = &{1'b0, mdu_start, mdu_div, id_hilo};
  assign mdu_busy_s   = 1'b0;
  assign mdu_done_s   = 1'b0;
  assign hilo_hz_s    = 1'b0;
`endif

  assign loaduse_hz_s = ex_memread && (ex_wreg != REG_ZERO) &&
                        ((id_use_rs && (id_rs == ex_wreg)) ||
                         (id_use_rt && (id_rt == ex_wreg)));

  // Priority: reset, memory freeze, taken branch, then ID-stage stalls.
  always_comb begin
    pc_en_s      = 1'b1;
    ifid_en_s    = 1'b1;
    ifid_flush_s = 1'b0;
    idex_en_s    = 1'b1;
    idex_flush_s = 1'b0;
    exmem_en_s   = 1'b1;
    memwb_en_s   = 1'b1;
    if (!rst_n) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
      memwb_en_s = 1'b0;
    end else if (mem_stall) begin
      // The frozen EX keeps a taken branch, which is applied on release.
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
      memwb_en_s = 1'b0;
    end else if (ex_br_taken) begin
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (hilo_hz_s || loaduse_hz_s) begin
      pc_en_s      = 1'b0;
      ifid_en_s    = 1'b0;
      idex_flush_s = 1'b1;
    end else begin
      pc_en_s = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
    end else if (!pc_en_s && (stall_cnt_r != STALL_SAT)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign pc_en      = pc_en_s;
  assign ifid_en    = ifid_en_s;
  assign ifid_flush = ifid_flush_s;
  assign idex_en    = idex_en_s;
  assign idex_flush = idex_flush_s;
  assign exmem_en   = exmem_en_s;
  assign memwb_en   = memwb_en_s;
  assign mdu_busy   = mdu_busy_s;
  assign mdu_done   = mdu_done_s;
  assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a rule-level reference model,
// plus directed hazard scenarios. MDU checks follow MDU_STALL_EN.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_wreg;
  logic        id_use_rs, id_use_rt, id_hilo, ex_memread, ex_br_taken;
  logic        mdu_start, mdu_div, mem_stall;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic        mdu_busy, mdu_done;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: remaining MDU cycles and expected stall count.
  int          m_rem = 0;
  logic [31:0] m_cnt = 32'd0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_hilo(id_hilo),
    .ex_memread(ex_memread), .ex_wreg(ex_wreg), .ex_br_taken(ex_br_taken),
    .mdu_start(mdu_start), .mdu_div(mdu_div), .mem_stall(mem_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {pc_en,ifid_en,ifid_flush,idex_en,idex_flush,exmem_en,memwb_en}.
  function automatic logic [6:0] exp_ctrl();
    logic hz;
    hz = (ex_memread && ex_wreg != 5'd0 &&
          ((id_use_rs && id_rs == ex_wreg) || (id_use_rt && id_rt == ex_wreg)))
         || (m_rem > 0 && id_hilo);
    if (!rst_n)      return 7'b000_0000;
    if (mem_stall)   return 7'b000_0000;
    if (ex_br_taken) return 7'b111_1111;
    if (hz)          return 7'b000_1111;
    return 7'b110_1011;
  endfunction

  task automatic check_now(input string tag);
    logic [6:0] e;
    e = exp_ctrl();
    check({tag, "_ctrl"}, {25'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en},
          {25'd0, e});
    check({tag, "_mdu"}, {30'd0, mdu_busy, mdu_done}, {30'd0, m_rem > 0, m_rem == 1});
    check({tag, "_stall_cnt"}, stall_cnt, m_cnt);
  endtask

  // One cycle: drive at negedge, check settled outputs, then advance the model.
  task automatic cyc(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic hilo, input logic memrd,
                     input logic [4:0] wreg, input logic br, input logic st, input logic dv,
                     input logic ms);
    logic [6:0] e;
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_hilo = hilo;
    ex_memread = memrd; ex_wreg = wreg; ex_br_taken = br;
    mdu_start = st; mdu_div = dv; mem_stall = ms;
    #1;
    check_now(tag);
    e = exp_ctrl();
    @(posedge clk);
    if (!rst_n) begin
      m_rem = 0;
      m_cnt = 32'd0;
    end else begin
      if (!e[6] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`ifdef MDU_STALL_EN
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (st && !ms) m_rem = dv ? 32 : 4;
`endif
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] base;
    int done_at;
    rst_n = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_hilo = 1'b0;
    ex_memread = 1'b0; ex_wreg = 5'd0; ex_br_taken = 1'b0;
    mdu_start = 1'b0; mdu_div = 1'b0; mem_stall = 1'b0;

    idle("reset");
    idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_reset");

    // Load-use: one bubble, then the EX bubble carries no load.
    cyc("lu_stall", 5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_pc_en", {31'd0, pc_en}, 32'd0);
    cyc("lu_after", 5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_after_pc_en", {31'd0, pc_en}, 32'd1);
    cyc("lu_rt", 5'd1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);

    // r0 destination never stalls.
    cyc("lu_r0", 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_r0_pc_en", {31'd0, pc_en}, 32'd1);

    // Branch overrides load-use.
    cyc("br_lu", 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("br_lu_flush", {30'd0, ifid_flush, idex_flush}, 32'd3);

    // Memory freeze holding a taken branch for three cycles.
    base = m_cnt;
    for (int i = 0; i < 3; i++)
      cyc("freeze", 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("freeze_rel", 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("freeze_cnt", stall_cnt, base + 32'd3);
    check("freeze_rel_flush", {30'd0, ifid_flush, idex_flush}, 32'd3);

`ifdef MDU_STALL_EN
    // Divide followed by a HILO reader: stalled through the done cycle.
    cyc("div_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    done_at = -1;
    for (int i = 0; i < 33; i++) begin
      cyc("div_hilo", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (mdu_done === 1'b1) done_at = i;
    end
    check("div_done_at", done_at, 32'd31);
    check("div_released_pc_en", {31'd0, pc_en}, 32'd1);

    // Start during a freeze is deferred.
    cyc("mul_defer", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("mul_go", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle("mul_run");

    // Reset with ten cycles left aborts silently.
    cyc("abort_start", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    while (m_rem > 10) idle("abort_run");
    check("abort_busy_before", {31'd0, mdu_busy}, 32'd1);
`endif
    @(negedge clk);
    rst_n = 1'b0;
    m_rem = 0;
    m_cnt = 32'd0;
    #1;
    check("rst_busy", {30'd0, mdu_busy, mdu_done}, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check_now("rst_mid");
    idle("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
